hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the 5-stage MIPS pipeline; successor to the single-cycle hazard logic.
//  - Keeps the existing forwarding, load-use and branch/jr stall rules.
//  - Adds a per-register busy scoreboard for long-latency ops (variable-latency loads, mul/div),
//    so D stalls only on true dependences.
//  - Adds a serialising FSM that drains all outstanding ops before a sync instruction (mtc0/eret/syscall).
// PARAMETERS
//  REG_AW       5  GPR address width; NUM_REGS = 2**REG_AW; register 0 never busy, never forwarded
//  MAX_PEND     4  max outstanding long ops (GPR + HILO combined); range 1..15
//  PEND_W       4  width of pend_cnt; must hold MAX_PEND
// PORTS
//  clk          in   1       pipeline clock
//  rst          in   1       asynchronous, active-high reset
//  rsD,rtD      in   REG_AW  decode source regs
//  branchD,jumpD,jrD,balD in 1  decode control (balD: branch-and-link, never flushed)
//  syncD        in   1       decode holds a serialising instruction
//  usesHiloD    in   1       decode reads HI/LO (mfhi/mflo)
//  rsE,rtE,writeRegE in REG_AW  execute regs
//  regWriteE,memToRegE in 1  execute control
//  longIssueE   in   1       op leaving E this cycle is long-latency (sets busy bit)
//  longHiloE    in   1       that long op targets HI/LO rather than writeRegE
//  longDone     in   1       one long op completes this cycle
//  longDoneReg  in   REG_AW  completing GPR (ignored when longDoneHilo=1)
//  longDoneHilo in   1       completing op is HI/LO
//  writeRegM,writeRegW in REG_AW; regWriteM,memToRegM,regWriteW in 1
//  stallF,stallD,stallE out 1  stage holds
//  flushE       out  1       bubble into E
//  forwardAD,forwardBD out 1  M->D forward for branch compare
//  forwardAE,forwardBE out 2  10=M, 01=W, 00=regfile
//  busyVec      out  NUM_REGS  scoreboard state (bit0 tied 0)
//  hiloBusy     out  1       HI/LO has an outstanding writer
//  pendCnt      out  PEND_W  outstanding long-op count
// BEHAVIOUR
//  Reset: busyVec=0, hiloBusy=0, pendCnt=0, FSM=RUN; outputs are combinational from reset state
//    (all stalls/flush 0, forwards 00).
//  Forwarding is combinational, identical priority to before: M over W; reg 0 excluded.
//  Scoreboard update (posedge clk):
//    - set bit writeRegE when longIssueE & !longHiloE & !stallE & writeRegE!=0;
//    - set hiloBusy when longIssueE & longHiloE & !stallE;
//    - clear on longDone.
//  Same-cycle set and clear of the same target: set wins. Clear of a non-busy target: ignored,
//    pendCnt unchanged.
//  pendCnt: +1 on accepted issue, -1 on longDone, unchanged if both; never wraps.
//  sbStall = busy[rsD] | busy[rtD] | (usesHiloD & hiloBusy) | (longIssueE & pendCnt==MAX_PEND).
//    The pendCnt term also raises stallE: a structural hold with no flush.
//  lwStall, branchStall, jumpStall: same rules as the single-cycle unit.
//  FSM (2 states):
//    - RUN -> DRAIN when syncD & pendCnt!=0 & !stallD_other.
//    - DRAIN: stallF=stallD=1, flushE=1.
//    - DRAIN -> RUN when pendCnt==0, or pendCnt==1 & longDone (transition visible next cycle).
//    - If pendCnt==0 at syncD: no stall.
//  stallD = lwStall|branchStall|jumpStall|sbStall|DRAIN; stallF = stallD.
//  stallE = structural hold only.
//  flushE = (stallD & !stallE) | jumpD | (branchD & !balD).
//  Reset mid-operation clears the scoreboard immediately. Ops completing after reset are ignored:
//    longDone with pendCnt==0 is a no-op.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    - adds outputs perfStallCyc[31:0] (cycles with stallD=1) and perfSbStallCyc[31:0]
//      (cycles with sbStall=1);
//    - counters reset to 0, saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent, no other behaviour change.
// STRUCTURE
//  Shared package hazard_pkg:
//    - fwd_sel_t encoding (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
//    - hz_state_t {HZ_RUN, HZ_DRAIN};
//    - default REG_AW.
//  One sub-module hazard_sb_regs: busy-bit array, hiloBusy, pendCnt with set/clear/saturation rules.
//  Top keeps the forwarding and stall equations plus the FSM.
// TESTING
//  1. lw $8 in E, add $9,$8,$8 in D -> stallD=stallF=flushE=1 one cycle; next cycle forwardAE=10.
//  2. div writes $5 (longIssueE, writeRegE=5); D reads $5 for 12 cycles -> stallD=1 until the cycle
//     after longDone,longDoneReg=5; busyVec[5] 1->0.
//  3. Set and clear of $7 in the same cycle -> busyVec[7]=1, pendCnt unchanged.
//  4. MAX_PEND=2: two long issues, third longIssueE -> stallE=1, flushE=0 until a longDone.
//  5. syncD with pendCnt=3 -> DRAIN for 3 completions, RUN on the cycle after pendCnt hits 0;
//     flushE=1 throughout DRAIN.
//  6. rst pulse while busyVec=0x24, pendCnt=2 -> all cleared asynchronously; a later longDone
//     leaves pendCnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit and its scoreboard.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package hazard_pkg;

    // Default GPR address width (32 architectural registers)
    localparam int HZ_REG_AW = 5;

    // Operand source select for the execute-stage ALU inputs
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Serialising FSM: normal issue, or draining long ops ahead of a sync instruction
    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_DRAIN = 1'b1
    } hz_state_t;

    // Memory stage has the younger result, so it takes priority over writeback
    function automatic fwd_sel_t fwdSel(input logic hitM, input logic hitW);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (hitW) sel = FWD_W;
        if (hitM) sel = FWD_M;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_regs.sv
// Busy scoreboard for long-latency ops: per-GPR busy bits, HI/LO busy bit, outstanding count.
// Latency: state updates on the clock edge after issue/completion; outputs are registered.
// Backpressure: pendFull tells the caller to hold issue; it never refuses an issue itself.
module hazard_sb_regs
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int MAX_PEND = 4,
    parameter int PEND_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issueVld,
    input  logic                     issueHilo,
    input  logic [REG_AW-1:0]        issueReg,
    input  logic                     doneVld,
    input  logic                     doneHilo,
    input  logic [REG_AW-1:0]        doneReg,
    output logic [(2**REG_AW)-1:0]   busyVec,
    output logic                     hiloBusy,
    output logic [PEND_W-1:0]        pendCnt,
    output logic                     pendFull
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    logic [(2**REG_AW)-1:0] busyNext;
    logic                   hiloNext;
    logic [PEND_W-1:0]      cntNext;
    logic                   doneHit;

    assign pendFull = (pendCnt == PEND_MAX);

    // A completion only counts if its target is actually busy; stale completions
    // (e.g. from ops issued before a reset) fall out here. Bit 0 is never set.
    always_comb begin
        doneHit = doneVld & (doneHilo ? hiloBusy : busyVec[doneReg]);
    end

    // Next busy state: clear first, then set, so a same-cycle set of the same target wins
    always_comb begin
        busyNext = busyVec;
        hiloNext = hiloBusy;
        if (doneHit && !doneHilo) busyNext[doneReg] = 1'b0;
        if (doneHit && doneHilo)  hiloNext = 1'b0;
        if (issueVld && !issueHilo) busyNext[issueReg] = 1'b1;
        if (issueVld && issueHilo)  hiloNext = 1'b1;
        busyNext[0] = 1'b0;
    end

    // Outstanding count: issue and completion in one cycle cancel; never wraps either way
    always_comb begin
        cntNext = pendCnt;
        if (issueVld && !doneHit && !pendFull) begin
            cntNext = pendCnt + PEND_W'(1);
        end else if (doneHit && !issueVld && (pendCnt != '0)) begin
            cntNext = pendCnt - PEND_W'(1);
        end
    end

    // Scoreboard state register; reset drops every outstanding op immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyVec  <= '0;
            hiloBusy <= 1'b0;
            pendCnt  <= '0;
        end else begin
            busyVec  <= busyNext;
            hiloBusy <= hiloNext;
            pendCnt  <= cntNext;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch/jr stalls, long-op scoreboard, sync drain.
// Latency: all stall/flush/forward outputs are combinational; scoreboard and FSM state update per clock.
// Backpressure: stallF/stallD hold fetch/decode; stallE holds execute when MAX_PEND ops are in flight. HAZARD_PERF_EN adds stall counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int MAX_PEND = 4,
    parameter int PEND_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_AW-1:0]       rsD,
    input  logic [REG_AW-1:0]       rtD,
    input  logic                    branchD,
    input  logic                    jumpD,
    input  logic                    jrD,
    input  logic                    balD,
    input  logic                    syncD,
    input  logic                    usesHiloD,
    input  logic [REG_AW-1:0]       rsE,
    input  logic [REG_AW-1:0]       rtE,
    input  logic [REG_AW-1:0]       writeRegE,
    input  logic                    regWriteE,
    input  logic                    memToRegE,
    input  logic                    longIssueE,
    input  logic                    longHiloE,
    input  logic                    longDone,
    input  logic [REG_AW-1:0]       longDoneReg,
    input  logic                    longDoneHilo,
    input  logic [REG_AW-1:0]       writeRegM,
    input  logic [REG_AW-1:0]       writeRegW,
    input  logic                    regWriteM,
    input  logic                    memToRegM,
    input  logic                    regWriteW,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    flushE,
    output logic                    forwardAD,
    output logic                    forwardBD,
    output logic [1:0]              forwardAE,
    output logic [1:0]              forwardBE,
    output logic [(2**REG_AW)-1:0]  busyVec,
    output logic                    hiloBusy,
    output logic [PEND_W-1:0]       pendCnt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]             perfStallCyc,
    output logic [31:0]             perfSbStallCyc
`endif
);

    hz_state_t state;
    hz_state_t stateNext;

    logic hitAEM, hitAEW, hitBEM, hitBEW;
    logic lwStall, branchStall, jumpStall, sbStall, stallOther;
    logic structStall, pendFull, drainReq, drainStall;
    logic issueAccept;

    // ---------------- forwarding ----------------
    assign hitAEM = (rsE != '0) & regWriteM & (rsE == writeRegM);
    assign hitAEW = (rsE != '0) & regWriteW & (rsE == writeRegW);
    assign hitBEM = (rtE != '0) & regWriteM & (rtE == writeRegM);
    assign hitBEW = (rtE != '0) & regWriteW & (rtE == writeRegW);

    assign forwardAE = fwdSel(hitAEM, hitAEW);
    assign forwardBE = fwdSel(hitBEM, hitBEW);

    // Branch comparator in D can only take results already sitting in M
    assign forwardAD = (rsD != '0) & regWriteM & (rsD == writeRegM);
    assign forwardBD = (rtD != '0) & regWriteM & (rtD == writeRegM);

    // ---------------- classic stalls ----------------
    assign lwStall     = memToRegE & ((rtE == rsD) | (rtE == rtD));
    assign branchStall = branchD &
                         ((regWriteE & ((writeRegE == rsD) | (writeRegE == rtD))) |
                          (memToRegM & ((writeRegM == rsD) | (writeRegM == rtD))));
    assign jumpStall   = jrD &
                         ((regWriteE & (writeRegE == rsD)) |
                          (memToRegM & (writeRegM == rsD)));

    // ---------------- scoreboard ----------------
    // A long op with no architectural target (GPR 0, not HI/LO) has nothing to
    // track, so it is not counted; otherwise its completion could never retire it.
    assign structStall = longIssueE & pendFull;
    assign issueAccept = longIssueE & ~structStall & (longHiloE | (writeRegE != '0));

    hazard_sb_regs #(
        .REG_AW   (REG_AW),
        .MAX_PEND (MAX_PEND),
        .PEND_W   (PEND_W)
    ) u_sb_regs (
        .clk       (clk),
        .rst       (rst),
        .issueVld  (issueAccept),
        .issueHilo (longHiloE),
        .issueReg  (writeRegE),
        .doneVld   (longDone),
        .doneHilo  (longDoneHilo),
        .doneReg   (longDoneReg),
        .busyVec   (busyVec),
        .hiloBusy  (hiloBusy),
        .pendCnt   (pendCnt),
        .pendFull  (pendFull)
    );

    assign sbStall    = busyVec[rsD] | busyVec[rtD] | (usesHiloD & hiloBusy) | structStall;
    assign stallOther = lwStall | branchStall | jumpStall | sbStall;
    assign drainReq   = syncD & (pendCnt != '0);

    // ---------------- serialising FSM ----------------
    // State register for the sync drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HZ_RUN;
        else     state <= stateNext;
    end

    // The sync instruction is held from the very cycle it is seen with ops in
    // flight, so it cannot slip into E before the drain state is registered.
    always_comb begin
        stateNext  = state;
        drainStall = 1'b0;
        case (state)
            HZ_RUN: begin
                if (drainReq) begin
                    drainStall = 1'b1;
                    if (!stallOther) stateNext = HZ_DRAIN;
                end
            end
            HZ_DRAIN: begin
                drainStall = 1'b1;
                if ((pendCnt == '0) || ((pendCnt == PEND_W'(1)) && longDone)) begin
                    stateNext = HZ_RUN;
                end
            end
            default: stateNext = HZ_RUN;
        endcase
    end

    // ---------------- stage controls ----------------
    assign stallD = stallOther | drainStall;
    assign stallF = stallD;
    assign stallE = structStall;
    assign flushE = (stallD & ~stallE) | jumpD | (branchD & ~balD);

`ifdef HAZARD_PERF_EN
    // Saturating stall-cycle counters for performance monitoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfStallCyc   <= '0;
            perfSbStallCyc <= '0;
        end else begin
            if (stallD && (perfStallCyc != '1))    perfStallCyc   <= perfStallCyc + 32'd1;
            if (sbStall && (perfSbStallCyc != '1)) perfSbStallCyc <= perfSbStallCyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table vectors, directed corner sequences, random vs model.
// Latency: checks combinational outputs mid-cycle, registered state after each edge.
// Backpressure: a second instance with MAX_PEND=2 exercises the structural execute hold.
module tb_hazard_scoreboard;

    logic clk, rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW, longDoneReg;
    logic branchD, jumpD, jrD, balD, syncD, usesHiloD;
    logic regWriteE, memToRegE, longIssueE, longHiloE, longDone, longDoneHilo;
    logic regWriteM, memToRegM, regWriteW;

    logic stallF, stallD, stallE, flushE, forwardAD, forwardBD, hiloBusy;
    logic [1:0] forwardAE, forwardBE;
    logic [31:0] busyVec;
    logic [3:0] pendCnt;

    logic stallF2, stallD2, stallE2, flushE2, forwardAD2, forwardBD2, hiloBusy2;
    logic [1:0] forwardAE2, forwardBE2;
    logic [31:0] busyVec2;
    logic [3:0] pendCnt2;

    int nChecks = 0;
    int nFail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .MAX_PEND(4), .PEND_W(4)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
        .jrD(jrD), .balD(balD), .syncD(syncD), .usesHiloD(usesHiloD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .memToRegE(memToRegE),
        .longIssueE(longIssueE), .longHiloE(longHiloE), .longDone(longDone),
        .longDoneReg(longDoneReg), .longDoneHilo(longDoneHilo), .writeRegM(writeRegM),
        .writeRegW(writeRegW), .regWriteM(regWriteM), .memToRegM(memToRegM),
        .regWriteW(regWriteW), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .busyVec(busyVec),
        .hiloBusy(hiloBusy), .pendCnt(pendCnt)
    );

    hazard_scoreboard #(.REG_AW(5), .MAX_PEND(2), .PEND_W(4)) dut2 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
        .jrD(jrD), .balD(balD), .syncD(syncD), .usesHiloD(usesHiloD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .memToRegE(memToRegE),
        .longIssueE(longIssueE), .longHiloE(longHiloE), .longDone(longDone),
        .longDoneReg(longDoneReg), .longDoneHilo(longDoneHilo), .writeRegM(writeRegM),
        .writeRegW(writeRegW), .regWriteM(regWriteM), .memToRegM(memToRegM),
        .regWriteW(regWriteW), .stallF(stallF2), .stallD(stallD2), .stallE(stallE2),
        .flushE(flushE2), .forwardAD(forwardAD2), .forwardBD(forwardBD2),
        .forwardAE(forwardAE2), .forwardBE(forwardBE2), .busyVec(busyVec2),
        .hiloBusy(hiloBusy2), .pendCnt(pendCnt2)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clearIn();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
        longDoneReg = 0; branchD = 0; jumpD = 0; jrD = 0; balD = 0; syncD = 0; usesHiloD = 0;
        regWriteE = 0; memToRegE = 0; longIssueE = 0; longHiloE = 0; longDone = 0;
        longDoneHilo = 0; regWriteM = 0; memToRegM = 0; regWriteW = 0;
    endtask

    // ---------------- reference model ----------------
    bit mBusy [32];
    bit mHilo;
    int mCnt;
    bit mDrain;
    bit mFull, mOther;
    logic eStallD, eStallE, eFlushE, eFAD, eFBD;
    logic [1:0] eFAE, eFBE;
    logic [31:0] eBusy;

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mBusy[r] = 0;
        mHilo = 0; mCnt = 0; mDrain = 0;
    endtask

    task automatic doReset();
        clearIn();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    function automatic logic [1:0] refFwd(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (regWriteM && r == writeRegM) return 2'd2;
        if (regWriteW && r == writeRegW) return 2'd1;
        return 2'd0;
    endfunction

    task automatic refEval();
        bit lw, br, jr, sb;
        mFull = longIssueE && (mCnt == 4);
        lw = memToRegE && (rtE == rsD || rtE == rtD);
        br = branchD && ((regWriteE && (writeRegE == rsD || writeRegE == rtD)) ||
                         (memToRegM && (writeRegM == rsD || writeRegM == rtD)));
        jr = jrD && ((regWriteE && writeRegE == rsD) || (memToRegM && writeRegM == rsD));
        sb = mBusy[rsD] || mBusy[rtD] || (usesHiloD && mHilo) || mFull;
        mOther  = lw || br || jr || sb;
        eStallD = mOther || mDrain || (syncD && mCnt != 0);
        eStallE = mFull;
        eFlushE = (eStallD && !eStallE) || jumpD || (branchD && !balD);
        eFAD = (rsD != 0) && regWriteM && (rsD == writeRegM);
        eFBD = (rtD != 0) && regWriteM && (rtD == writeRegM);
        eFAE = refFwd(rsE);
        eFBE = refFwd(rtE);
        for (int r = 0; r < 32; r++) eBusy[r] = mBusy[r];
    endtask

    task automatic refUpdate();
        bit accept, hit;
        accept = longIssueE && !mFull && (longHiloE || writeRegE != 0);
        hit = longDone && (longDoneHilo ? mHilo : (longDoneReg != 0 && mBusy[longDoneReg]));
        if (!mDrain) mDrain = syncD && mCnt != 0 && !mOther;
        else         mDrain = !(mCnt == 0 || (mCnt == 1 && longDone));
        if (hit) begin
            if (longDoneHilo) mHilo = 0; else mBusy[longDoneReg] = 0;
            if (mCnt > 0) mCnt--;
        end
        if (accept) begin
            if (longHiloE) mHilo = 1; else mBusy[writeRegE] = 1;
            mCnt++;
        end
    endtask

    task automatic issue(input logic [4:0] r);
        clearIn();
        longIssueE = 1; writeRegE = r; regWriteE = 1;
        cyc();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] vRsD, vRtD, vRsE, vRtE, vWrE, vWrM, vWrW;
        logic vBr, vJmp, vJr, vBal, vRwE, vM2rE, vRwM, vM2rM, vRwW;
        logic xStallD, xFlushE, xFAD, xFBD;
        logic [1:0] xFAE, xFBE;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
        vecs[1] = '{1,2,3,4,0,3,4,   0,0,0,0,0,0,1,0,1, 0,0,0,0,2'd2,2'd1};
        vecs[2] = '{1,2,6,6,0,6,6,   0,0,0,0,0,0,1,0,1, 0,0,0,0,2'd2,2'd2};
        vecs[3] = '{0,0,0,0,0,0,0,   0,0,0,0,0,0,1,0,1, 0,0,0,0,2'd0,2'd0};
        vecs[4] = '{8,8,1,8,8,0,0,   0,0,0,0,1,1,0,0,0, 1,1,0,0,2'd0,2'd0};
        vecs[5] = '{10,11,0,0,0,10,0,1,0,0,0,0,0,1,0,0, 0,1,1,0,2'd0,2'd0};
        vecs[6] = '{12,13,0,0,13,0,0,1,0,0,1,1,0,0,0,0, 1,1,0,0,2'd0,2'd0};
        vecs[7] = '{14,15,0,0,0,0,0, 1,0,0,1,0,0,0,0,0, 0,0,0,0,2'd0,2'd0};
        vecs[8] = '{16,0,0,0,0,16,0, 0,0,1,0,0,0,1,1,0, 1,1,1,0,2'd0,2'd0};
        vecs[9] = '{1,2,0,0,0,0,0,   0,1,0,0,0,0,0,0,0, 0,1,0,0,2'd0,2'd0};

        rst = 1'b0;
        clearIn();
        #2;
        doReset();

        // reset state
        mid();
        chk("rst_stallD", stallD, 0);
        chk("rst_stallF", stallF, 0);
        chk("rst_stallE", stallE, 0);
        chk("rst_flushE", flushE, 0);
        chk("rst_fwdAE", forwardAE, 0);
        chk("rst_fwdBE", forwardBE, 0);
        chk("rst_busyVec", busyVec, 0);
        chk("rst_hiloBusy", hiloBusy, 0);
        chk("rst_pendCnt", pendCnt, 0);
        cyc();

        // table vectors on a clean scoreboard
        for (int i = 0; i < 10; i++) begin
            clearIn();
            rsD = vecs[i].vRsD; rtD = vecs[i].vRtD; rsE = vecs[i].vRsE; rtE = vecs[i].vRtE;
            writeRegE = vecs[i].vWrE; writeRegM = vecs[i].vWrM; writeRegW = vecs[i].vWrW;
            branchD = vecs[i].vBr; jumpD = vecs[i].vJmp; jrD = vecs[i].vJr; balD = vecs[i].vBal;
            regWriteE = vecs[i].vRwE; memToRegE = vecs[i].vM2rE; regWriteM = vecs[i].vRwM;
            memToRegM = vecs[i].vM2rM; regWriteW = vecs[i].vRwW;
            mid();
            chk($sformatf("vec%0d_stallD", i), stallD, vecs[i].xStallD);
            chk($sformatf("vec%0d_stallF", i), stallF, vecs[i].xStallD);
            chk($sformatf("vec%0d_flushE", i), flushE, vecs[i].xFlushE);
            chk($sformatf("vec%0d_fwdAD", i), forwardAD, vecs[i].xFAD);
            chk($sformatf("vec%0d_fwdBD", i), forwardBD, vecs[i].xFBD);
            chk($sformatf("vec%0d_fwdAE", i), forwardAE, vecs[i].xFAE);
            chk($sformatf("vec%0d_fwdBE", i), forwardBE, vecs[i].xFBE);
            cyc();
        end

        // lw $8 then add $9,$8,$8: one stall, then M forwarding
        doReset();
        memToRegE = 1; regWriteE = 1; rtE = 8; writeRegE = 8; rsD = 8; rtD = 8;
        mid();
        chk("lw_stallD", stallD, 1);
        chk("lw_stallF", stallF, 1);
        chk("lw_flushE", flushE, 1);
        cyc();
        clearIn();
        rsE = 8; rtE = 8; writeRegM = 8; regWriteM = 1; memToRegM = 1;
        mid();
        chk("lw_fwdAE", forwardAE, 2'b10);
        chk("lw_fwdBE", forwardBE, 2'b10);
        chk("lw_next_stallD", stallD, 0);
        cyc();

        // div to $5, dependent reader held until the cycle after completion
        doReset();
        issue(5);
        for (int i = 0; i < 12; i++) begin
            clearIn();
            rsD = 5;
            longDone = (i == 9); longDoneReg = 5;
            mid();
            chk($sformatf("div_stallD_c%0d", i), stallD, (i <= 9));
            chk($sformatf("div_busy5_c%0d", i), busyVec[5], (i <= 9));
            cyc();
        end
        clearIn();
        mid();
        chk("div_pendCnt_end", pendCnt, 0);

        // same-cycle set and clear of $7
        doReset();
        issue(7);
        clearIn();
        longIssueE = 1; writeRegE = 7; regWriteE = 1; longDone = 1; longDoneReg = 7;
        cyc();
        clearIn();
        mid();
        chk("setclr_busy7", busyVec[7], 1);
        chk("setclr_pendCnt", pendCnt, 1);
        cyc();

        // structural hold with MAX_PEND=2
        doReset();
        issue(2);
        issue(3);
        for (int i = 0; i < 3; i++) begin
            clearIn();
            longIssueE = 1; writeRegE = 4; regWriteE = 1;
            mid();
            chk($sformatf("full_stallE_c%0d", i), stallE2, 1);
            chk($sformatf("full_flushE_c%0d", i), flushE2, 0);
            chk($sformatf("full_stallD_c%0d", i), stallD2, 1);
            chk($sformatf("full_pendCnt_c%0d", i), pendCnt2, 2);
            cyc();
        end
        clearIn();
        longIssueE = 1; writeRegE = 4; regWriteE = 1; longDone = 1; longDoneReg = 2;
        mid();
        chk("full_done_stallE", stallE2, 1);
        cyc();
        clearIn();
        longIssueE = 1; writeRegE = 4; regWriteE = 1;
        mid();
        chk("full_release_stallE", stallE2, 0);
        chk("full_release_pendCnt", pendCnt2, 1);
        cyc();
        clearIn();
        mid();
        chk("full_after_pendCnt", pendCnt2, 2);
        chk("full_after_busy4", busyVec2[4], 1);

        // sync drain with three ops outstanding
        doReset();
        issue(2);
        issue(3);
        issue(4);
        clearIn();
        mid();
        chk("drain_pre_pendCnt", pendCnt, 3);
        cyc();
        for (int i = 0; i < 7; i++) begin
            clearIn();
            syncD = 1;
            longDone = (i == 1 || i == 3 || i == 5);
            longDoneReg = 5'(2 + i / 2);
            mid();
            chk($sformatf("drain_stallD_c%0d", i), stallD, (i <= 5));
            chk($sformatf("drain_flushE_c%0d", i), flushE, (i <= 5));
            chk($sformatf("drain_pendCnt_c%0d", i), pendCnt, 32'(3 - i / 2));
            cyc();
        end

        // asynchronous reset mid-operation
        doReset();
        issue(2);
        issue(5);
        clearIn();
        mid();
        chk("arst_pre_busy", busyVec, 32'h24);
        chk("arst_pre_pendCnt", pendCnt, 2);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busyVec, 0);
        chk("arst_pendCnt", pendCnt, 0);
        rst = 1'b0;
        modelReset();
        cyc();
        longDone = 1; longDoneReg = 2;
        cyc();
        clearIn();
        mid();
        chk("arst_late_done_pendCnt", pendCnt, 0);
        chk("arst_late_done_busy", busyVec, 0);
        cyc();

        // randomized run against the model
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rsD = 5'($urandom_range(0, 7));
            rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7));
            rtE = 5'($urandom_range(0, 7));
            writeRegE = 5'($urandom_range(0, 7));
            writeRegM = 5'($urandom_range(0, 7));
            writeRegW = 5'($urandom_range(0, 7));
            longDoneReg = 5'($urandom_range(0, 7));
            branchD = ($urandom_range(0, 99) < 15);
            jumpD = ($urandom_range(0, 99) < 5);
            jrD = ($urandom_range(0, 99) < 8);
            balD = ($urandom_range(0, 99) < 20);
            syncD = ($urandom_range(0, 99) < 6);
            usesHiloD = ($urandom_range(0, 99) < 20);
            regWriteE = ($urandom_range(0, 99) < 50);
            memToRegE = ($urandom_range(0, 99) < 15);
            longIssueE = ($urandom_range(0, 99) < 30);
            longHiloE = ($urandom_range(0, 99) < 25);
            longDone = ($urandom_range(0, 99) < 30);
            longDoneHilo = ($urandom_range(0, 99) < 25);
            regWriteM = ($urandom_range(0, 99) < 50);
            memToRegM = ($urandom_range(0, 99) < 20);
            regWriteW = ($urandom_range(0, 99) < 50);
            refEval();
            mid();
            chk("rnd_stallF", stallF, eStallD);
            chk("rnd_stallD", stallD, eStallD);
            chk("rnd_stallE", stallE, eStallE);
            chk("rnd_flushE", flushE, eFlushE);
            chk("rnd_fwdAD", forwardAD, eFAD);
            chk("rnd_fwdBD", forwardBD, eFBD);
            chk("rnd_fwdAE", forwardAE, eFAE);
            chk("rnd_fwdBE", forwardBE, eFBE);
            chk("rnd_busyVec", busyVec, eBusy);
            chk("rnd_hiloBusy", hiloBusy, mHilo);
            chk("rnd_pendCnt", pendCnt, 32'(mCnt));
            refUpdate();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Safety net: the test is linear, but never let a run hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
